// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: shared mode encodings, luma weights and FSM state type for the gray converter.
package rgb2gray_pkg;
    typedef enum logic [1:0] {
        MODE_LUMA  = 2'd0,
        MODE_FAST  = 2'd1,
        MODE_GREEN = 2'd2,
        MODE_MAX   = 2'd3
    } mode_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;
endpackage

// File: rtl/rgb2gray_stream_if.sv
// rgb2gray_stream_if: control, frame-store read and gray stream signals of the converter.
interface rgb2gray_stream_if import rgb2gray_pkg::*; #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 18
);
    logic                 start;
    mode_e                mode;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic                 mem_en;
    logic [DATAWIDTH-1:0] mem_r;
    logic [DATAWIDTH-1:0] mem_g;
    logic [DATAWIDTH-1:0] mem_b;
    logic [DATAWIDTH-1:0] gray;
    logic                 gray_valid;
    logic                 gray_ready;
    logic                 gray_eol;
    logic                 gray_eof;
    logic                 busy;
    logic                 done;
    modport slave (
        input  start, mode, mem_r, mem_g, mem_b, gray_ready,
        output mem_addr, mem_en, gray, gray_valid, gray_eol, gray_eof, busy, done
    );
    modport master (
        output start, mode, mem_r, mem_g, mem_b, gray_ready,
        input  mem_addr, mem_en, gray, gray_valid, gray_eol, gray_eof, busy, done
    );
endinterface

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous first-word-fall-through FIFO with occupancy count for credit flow.
module pix_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;
    assign push      = wr_en_i && (count_q != CW'(DEPTH));
    assign pop       = rd_en_i && valid_o;
    assign valid_o   = count_q != '0;
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/rgb2gray_stream.sv
// rgb2gray_stream: walks a planar RGB frame store and streams converted gray pixels
// with line/frame markers under credit-based flow control.
module rgb2gray_stream import rgb2gray_pkg::*; #(
    parameter int DATAWIDTH  = 8,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int ADDRWIDTH  = 18,
    parameter int RD_LATENCY = 1
) (
    input logic              CLK,
    input logic              RSTn,
    rgb2gray_stream_if.slave bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int D    = RD_LATENCY + 2;
    localparam int CW   = $clog2(D + 1);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int MW   = DATAWIDTH + 10;
    localparam int FW   = DATAWIDTH + 2;
    state_e                state_q;
    state_e                state_d;
    mode_e                 mode_q;
    logic [ADDRWIDTH-1:0]  addr_q;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] eol_q;
    logic [RD_LATENCY-1:0] eof_q;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [FW-1:0]         head;
    logic [DATAWIDTH-1:0]  px;
    logic [DATAWIDTH-1:0]  mx;
    logic [MW-1:0]         ext_r;
    logic [MW-1:0]         ext_g;
    logic [MW-1:0]         ext_b;
    logic                  fifo_valid;
    logic                  issue;
    logic                  pop;
    logic                  last_addr;
    logic                  x_last;
    logic                  y_last;
    // Credits cover everything already requested: queued pixels plus reads still in the pipe.
    assign inflight  = CW'($countones(vld_q));
    assign issue     = (state_q == S_RUN) && (int'(fifo_count) + int'(inflight) < D);
    assign pop       = fifo_valid && bus.gray_ready;
    assign last_addr = addr_q == ADDRWIDTH'(NPIX - 1);
    assign x_last    = x_q == XW'(IMG_W - 1);
    assign y_last    = y_q == YW'(IMG_H - 1);
    always_ff @(posedge CLK) begin
        state_q <= RSTn ? state_d : S_IDLE;
    end
    always_comb begin
        state_d = state_q == S_IDLE  ? (bus.start ? S_RUN : S_IDLE) :
                  state_q == S_RUN   ? ((issue && last_addr) ? S_DRAIN : S_RUN) :
                  state_q == S_DRAIN ? ((pop && head[FW-1]) ? S_DONE : S_DRAIN) :
                                       S_IDLE;
    end
    always_comb begin
        bus.mem_en     = issue;
        bus.mem_addr   = addr_q;
        bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
        bus.done       = state_q == S_DONE;
        bus.gray_valid = fifo_valid;
        bus.gray       = fifo_valid ? head[DATAWIDTH-1:0] : '0;
        bus.gray_eol   = fifo_valid && head[FW-2];
        bus.gray_eof   = fifo_valid && head[FW-1];
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) mode_q <= MODE_LUMA;
        else if (state_q == S_IDLE && bus.start) mode_q <= bus.mode;
    end
    always_ff @(posedge CLK) begin
        if (!RSTn || state_q == S_IDLE) begin
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (issue) begin
            addr_q <= last_addr ? '0 : addr_q + 1'b1;
            x_q    <= x_last ? '0 : x_q + 1'b1;
            if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            vld_q <= '0;
            eol_q <= '0;
            eof_q <= '0;
        end else begin
            vld_q[0] <= issue;
            eol_q[0] <= x_last;
            eof_q[0] <= x_last && y_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                eol_q[i] <= eol_q[i-1];
                eof_q[i] <= eof_q[i-1];
            end
        end
    end
    assign ext_r = MW'(bus.mem_r);
    assign ext_g = MW'(bus.mem_g);
    assign ext_b = MW'(bus.mem_b);
    always_comb begin
        mx = (bus.mem_r > bus.mem_g) ? bus.mem_r : bus.mem_g;
        mx = (bus.mem_b > mx) ? bus.mem_b : mx;
        px = mode_q == MODE_LUMA  ? DATAWIDTH'((MW'(LUMA_R) * ext_r + MW'(LUMA_G) * ext_g + MW'(LUMA_B) * ext_b) >> 8) :
             mode_q == MODE_FAST  ? DATAWIDTH'((ext_r + (ext_g << 1) + ext_b) >> 2) :
             mode_q == MODE_GREEN ? bus.mem_g :
                                    mx;
    end
    pix_fifo #(
        .WIDTH (FW),
        .DEPTH (D)
    ) u_fifo (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .wr_en_i   (vld_q[RD_LATENCY-1]),
        .wr_data_i ({eof_q[RD_LATENCY-1], eol_q[RD_LATENCY-1], px}),
        .rd_en_i   (bus.gray_ready),
        .rd_data_o (head),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );
endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb_rgb2gray_stream: directed checks of a 4x2/latency-1 instance and a 16x16/latency-3 instance.
module tb_rgb2gray_stream;
    import rgb2gray_pkg::*;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] rv, gv, bv;
    logic [17:0] pb0, pb1, pb2;
    always #5 clk = ~clk;
    rgb2gray_stream_if #(.DATAWIDTH(8), .ADDRWIDTH(18)) ia ();
    rgb2gray_stream_if #(.DATAWIDTH(8), .ADDRWIDTH(18)) ib ();
    rgb2gray_stream #(
        .DATAWIDTH(8), .IMG_W(4), .IMG_H(2), .ADDRWIDTH(18), .RD_LATENCY(1)
    ) dut_a (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (ia)
    );
    rgb2gray_stream #(
        .DATAWIDTH(8), .IMG_W(16), .IMG_H(16), .ADDRWIDTH(18), .RD_LATENCY(3)
    ) dut_b (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (ib)
    );
    assign ia.mem_r = rv;
    assign ia.mem_g = gv;
    assign ia.mem_b = bv;
    // Three-cycle read latency store whose green plane is addr^0x5a, so order is checkable.
    always_ff @(posedge clk) begin
        pb0 <= ib.mem_addr;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ib.mem_r = pb2[7:0] + 8'd1;
    assign ib.mem_g = pb2[7:0] ^ 8'h5a;
    assign ib.mem_b = ~pb2[7:0];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic run_a(input string tag, input mode_e m, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic [7:0] exp, input bit poke);
        int n, pix, bad, issued, issue_bad, dones, done_at;
        logic [7:0] eolm, eofm;
        n = 1; pix = 0; bad = 0; issued = 0; issue_bad = 0; dones = 0; done_at = 0;
        eolm = '0; eofm = '0;
        rv = r; gv = g; bv = b;
        ia.mode = m; ia.gray_ready = 1'b1; ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        chk({tag, " first_en"}, 32'(ia.mem_en), 1);
        chk({tag, " busy"}, 32'(ia.busy), 1);
        while (n < 40 && (done_at == 0 || n < done_at + 4)) begin
            if (poke && n == 3) begin ia.start = 1'b1; ia.mode = MODE_GREEN; end
            if (poke && n == 4) ia.start = 1'b0;
            if (ia.mem_en) begin
                if (ia.mem_addr !== 18'(issued)) issue_bad++;
                issued++;
            end
            if (ia.gray_valid && ia.gray_ready) begin
                if (ia.gray !== exp) bad++;
                if (pix < 8) begin eolm[pix] = ia.gray_eol; eofm[pix] = ia.gray_eof; end
                pix++;
            end
            if (ia.done) begin
                dones++;
                if (done_at == 0) done_at = n;
            end
            tick();
            n++;
        end
        chk({tag, " pixels"}, pix, 8);
        chk({tag, " bad_gray"}, bad, 0);
        chk({tag, " eol_mask"}, 32'(eolm), 32'h88);
        chk({tag, " eof_mask"}, 32'(eofm), 32'h80);
        chk({tag, " done_cycle"}, done_at, 11);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " issued"}, issued, 8);
        chk({tag, " addr_order"}, issue_bad, 0);
    endtask
    task automatic run_b(input string tag, input bit rnd);
        int n, pix, bad, occ, max_occ, stall_bad, first_en, first_v, done_at;
        bit prev_stall;
        logic [9:0] prev;
        logic [7:0] exp8;
        n = 1; pix = 0; bad = 0; occ = 0; max_occ = 0; stall_bad = 0;
        first_en = -1; first_v = -1; done_at = 0; prev_stall = 1'b0; prev = '0;
        ib.mode = MODE_GREEN; ib.gray_ready = 1'b1; ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        while (n < 3000 && done_at == 0) begin
            ib.gray_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && !(ib.gray_valid && {ib.gray_eof, ib.gray_eol, ib.gray} === prev)) stall_bad++;
            if (ib.mem_en) begin
                if (first_en < 0) first_en = n;
                occ++;
            end
            if (occ > max_occ) max_occ = occ;
            if (ib.gray_valid && first_v < 0) first_v = n;
            if (ib.gray_valid && ib.gray_ready) begin
                exp8 = 8'(pix) ^ 8'h5a;
                if (ib.gray !== exp8 || ib.gray_eol !== (pix % 16 == 15) || ib.gray_eof !== (pix == 255)) bad++;
                pix++;
                occ--;
            end
            prev_stall = ib.gray_valid && !ib.gray_ready;
            prev = {ib.gray_eof, ib.gray_eol, ib.gray};
            if (ib.done) done_at = n;
            tick();
            n++;
        end
        chk({tag, " pixels"}, pix, 256);
        chk({tag, " bad_pixels"}, bad, 0);
        chk({tag, " occupancy_le_5"}, 32'(max_occ <= 5), 1);
        chk({tag, " stall_unstable"}, stall_bad, 0);
        if (!rnd) begin
            chk({tag, " first_en"}, first_en, 1);
            chk({tag, " en_to_valid"}, first_v - first_en, 4);
            chk({tag, " done_cycle"}, done_at, 261);
        end else begin
            chk({tag, " done_seen"}, 32'(done_at != 0), 1);
        end
    endtask
    initial begin
        rv = '0; gv = '0; bv = '0;
        ia.start = 1'b0; ia.mode = MODE_LUMA; ia.gray_ready = 1'b0;
        ib.start = 1'b0; ib.mode = MODE_LUMA; ib.gray_ready = 1'b0;
        tick();
        tick();
        chk("rst mem_en", 32'(ia.mem_en), 0);
        chk("rst mem_addr", 32'(ia.mem_addr), 0);
        chk("rst gray_valid", 32'(ia.gray_valid), 0);
        chk("rst busy", 32'(ia.busy), 0);
        chk("rst done", 32'(ia.done), 0);
        chk("rst b_valid", 32'(ib.gray_valid), 0);
        rstn = 1'b1;
        tick();
        run_a("luma200", MODE_LUMA, 8'd200, 8'd200, 8'd200, 8'd200, 1'b0);
        run_a("fast", MODE_FAST, 8'd10, 8'd100, 8'd50, 8'd65, 1'b0);
        run_a("green", MODE_GREEN, 8'd10, 8'd100, 8'd50, 8'd100, 1'b0);
        run_a("max", MODE_MAX, 8'd10, 8'd100, 8'd50, 8'd100, 1'b0);
        run_a("luma_r", MODE_LUMA, 8'd255, 8'd0, 8'd0, 8'd76, 1'b0);
        run_a("luma_g", MODE_LUMA, 8'd0, 8'd255, 8'd0, 8'd149, 1'b0);
        run_a("luma_b", MODE_LUMA, 8'd0, 8'd0, 8'd255, 8'd28, 1'b0);
        run_a("max_b", MODE_MAX, 8'd10, 8'd20, 8'd250, 8'd250, 1'b0);
        run_a("poke", MODE_FAST, 8'd10, 8'd100, 8'd50, 8'd65, 1'b1);
        rv = 8'd1; gv = 8'd60; bv = 8'd3;
        ia.mode = MODE_GREEN; ia.gray_ready = 1'b0; ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        repeat (4) tick();
        chk("pre_rst addr", 32'(ia.mem_addr), 3);
        chk("pre_rst valid", 32'(ia.gray_valid), 1);
        chk("pre_rst gray", 32'(ia.gray), 60);
        rstn = 1'b0;
        tick();
        chk("mid_rst mem_en", 32'(ia.mem_en), 0);
        chk("mid_rst mem_addr", 32'(ia.mem_addr), 0);
        chk("mid_rst valid", 32'(ia.gray_valid), 0);
        chk("mid_rst gray", 32'(ia.gray), 0);
        chk("mid_rst busy", 32'(ia.busy), 0);
        chk("mid_rst done", 32'(ia.done), 0);
        rstn = 1'b1;
        run_a("after_rst", MODE_GREEN, 8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        run_b("b_sustained", 1'b0);
        repeat (3) tick();
        run_b("b_random", 1'b1);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
